// File: rtl/matrix_loader_if.sv
// ============================================================================
//  Module   : matrix_port_if / sram_port_if
//  Brief    : Multiplier-side request port and SRAM-side read port of the
//             matrix loader, each with master/slave modports.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface matrix_port_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int BANDWIDTH  = 16
);
    logic                             matrix_enable;
    logic [ADDR_WIDTH-1:0]            matrix_addr;
    logic [DATA_WIDTH*BANDWIDTH-1:0]  matrix_data;
    logic                             matrix_ready;

    // master = multiplier, slave = loader
    modport master (
        output matrix_enable,
        output matrix_addr,
        input  matrix_data,
        input  matrix_ready
    );

    modport slave (
        input  matrix_enable,
        input  matrix_addr,
        output matrix_data,
        output matrix_ready
    );
endinterface

interface sram_port_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                   sram_en;
    logic [ADDR_WIDTH-1:0]  sram_addr;
    logic [DATA_WIDTH-1:0]  sram_rdata;

    // master = loader, slave = SRAM
    modport master (
        output sram_en,
        output sram_addr,
        input  sram_rdata
    );

    modport slave (
        input  sram_en,
        input  sram_addr,
        output sram_rdata
    );
endinterface

`default_nettype wire

// File: rtl/matrix_loader.sv
// ============================================================================
//  Module   : matrix_loader
//  Brief    : Fetches BANDWIDTH consecutive elements from a one-element-wide
//             weight SRAM and presents them as one wide word with a ready flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module matrix_loader #(
    parameter int NUM_ROWS   = 64,
    parameter int NUM_COLS   = 64,
    parameter int DATA_WIDTH = 16,
    parameter int BANDWIDTH  = 16,
    parameter int ADDR_WIDTH = $clog2(NUM_ROWS*NUM_COLS)
) (
    input  wire              clk,
    input  wire              rst,
    matrix_port_if.slave     mtx,
    sram_port_if.master      sram
);

    localparam int                  c_LW       = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_MEM_SIZE = (ADDR_WIDTH+1)'(NUM_ROWS*NUM_COLS);
    localparam logic [c_LW-1:0]     c_LAST     = c_LW'(BANDWIDTH-1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_FETCH = 4'b0010,
        S_DRAIN = 4'b0100,
        S_HOLD  = 4'b1000
    } state_t;

    state_t                          r_state;
    logic [ADDR_WIDTH-1:0]           r_base;
    logic [c_LW-1:0]                 r_issue_cnt;
    logic [c_LW-1:0]                 r_cap_cnt;
    logic [DATA_WIDTH*BANDWIDTH-1:0] r_data;
    logic                            r_ready;
    logic                            r_sram_en;
    logic [ADDR_WIDTH-1:0]           r_sram_addr;

    // Two-stage issue tracker: stage 1 mirrors the strobe on the SRAM port,
    // stage 2 lines up with the cycle in which sram_rdata is valid.
    logic                            r_p1_live;
    logic                            r_p1_real;
    logic [c_LW-1:0]                 r_p1_lane;
    logic                            r_p2_live;
    logic                            r_p2_real;
    logic [c_LW-1:0]                 r_p2_lane;

    logic [ADDR_WIDTH:0]             w_ea;
    logic                            w_in_range;
    logic                            w_busy;
    logic                            w_capture;

    assign w_ea       = {1'b0, r_base} + (ADDR_WIDTH+1)'(r_issue_cnt);
    assign w_in_range = (w_ea < c_MEM_SIZE);
    assign w_busy     = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_capture  = w_busy && mtx.matrix_enable && r_p2_live && r_p2_real;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_data      <= '0;
            r_ready     <= 1'b0;
            r_sram_en   <= 1'b0;
            r_sram_addr <= '0;
            r_p1_live   <= 1'b0;
            r_p1_real   <= 1'b0;
            r_p1_lane   <= '0;
            r_p2_live   <= 1'b0;
            r_p2_real   <= 1'b0;
            r_p2_lane   <= '0;
        end else begin
            r_sram_en <= 1'b0;
            r_p1_live <= 1'b0;
            r_p2_live <= r_p1_live;
            r_p2_real <= r_p1_real;
            r_p2_lane <= r_p1_lane;

            if (w_capture) begin
                r_data[int'(r_p2_lane)*DATA_WIDTH +: DATA_WIDTH] <= sram.sram_rdata;
            end
            if (w_busy && mtx.matrix_enable && r_p2_live) begin
                r_cap_cnt <= r_cap_cnt + c_LW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (mtx.matrix_enable) begin
                        r_base      <= mtx.matrix_addr;
                        r_data      <= '0;
                        r_issue_cnt <= '0;
                        r_cap_cnt   <= '0;
                        r_state     <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (!mtx.matrix_enable) begin
                        r_p2_live <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        // Out-of-range lanes still consume an issue slot so
                        // latency stays fixed; they just never touch the SRAM.
                        r_sram_en   <= w_in_range;
                        if (w_in_range) begin
                            r_sram_addr <= w_ea[ADDR_WIDTH-1:0];
                        end
                        r_p1_live   <= 1'b1;
                        r_p1_real   <= w_in_range;
                        r_p1_lane   <= r_issue_cnt;
                        r_issue_cnt <= r_issue_cnt + c_LW'(1);
                        if (r_issue_cnt == c_LAST) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (!mtx.matrix_enable) begin
                        r_p2_live <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (r_p2_live && (r_cap_cnt == c_LAST)) begin
                        r_ready <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (!mtx.matrix_enable) begin
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mtx.matrix_data  = r_data;
    assign mtx.matrix_ready = r_ready;
    assign sram.sram_en     = r_sram_en;
    assign sram.sram_addr   = r_sram_addr;

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
//  Module   : tb_matrix_loader
//  Brief    : Directed self-checking bench for matrix_loader with an SRAM model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_matrix_loader;

    localparam int c_AW  = 12;
    localparam int c_DW  = 16;
    localparam int c_BW  = 16;
    localparam int c_MEM = 4096;

    logic clk;
    logic rst;

    matrix_port_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .BANDWIDTH(c_BW)) mif ();
    sram_port_if   #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW))                   sif ();

    matrix_loader #(
        .NUM_ROWS   (64),
        .NUM_COLS   (64),
        .DATA_WIDTH (c_DW),
        .BANDWIDTH  (c_BW),
        .ADDR_WIDTH (c_AW)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .mtx  (mif.slave),
        .sram (sif.master)
    );

    logic [c_DW-1:0] mem [c_MEM];
    int              n_compared;
    int              n_mismatched;
    int              seen_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle read latency SRAM
    always @(posedge clk) begin
        if (sif.sram_en) sif.sram_rdata <= mem[sif.sram_addr];
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [255:0] exp_word(input int a);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < c_BW; k++) begin
            if (a + k < c_MEM) w[k*c_DW +: c_DW] = mem[a+k];
        end
        return w;
    endfunction

    // Raises enable with address a; returns edges from sampling edge to ready.
    task automatic do_request(input int a, output int lat, output int n_en);
        mif.matrix_enable = 1'b1;
        mif.matrix_addr   = c_AW'(a);
        n_en = 0;
        @(posedge clk);
        #1;
        lat = 0;
        while (!mif.matrix_ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (sif.sram_en) begin
                n_en++;
                seen_q.push_back(int'(sif.sram_addr));
            end
        end
    endtask

    task automatic release_req();
        mif.matrix_enable = 1'b0;
        step(1);
    endtask

    initial begin
        int           lat;
        int           n_en;
        int           n_bad;
        logic [255:0] held;

        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1;
        mif.matrix_enable = 1'b0;
        mif.matrix_addr   = '0;
        for (int i = 0; i < c_MEM; i++) mem[i] = c_DW'(i);
        step(3);

        check_val("rst_ready", 256'(mif.matrix_ready), 256'(0));
        check_val("rst_data",  mif.matrix_data, '0);
        check_val("rst_en",    256'(sif.sram_en), 256'(0));
        check_val("rst_addr",  256'(sif.sram_addr), 256'(0));
        rst = 1'b0;
        step(1);

        // Basic fetch from address 0
        seen_q.delete();
        do_request(0, lat, n_en);
        check_val("t1_latency", 256'(lat), 256'(18));
        check_val("t1_en_cnt",  256'(n_en), 256'(16));
        n_bad = 0;
        foreach (seen_q[j]) if (seen_q[j] != j) n_bad++;
        check_val("t1_addr_seq", 256'(n_bad), 256'(0));
        check_val("t1_data", mif.matrix_data, exp_word(0));
        release_req();

        // Top-of-memory request: half the lanes fall off the end
        for (int i = 0; i < c_MEM; i++) mem[i] = c_DW'(i) ^ 16'hA5A5;
        seen_q.delete();
        do_request(4088, lat, n_en);
        check_val("t2_latency", 256'(lat), 256'(18));
        check_val("t2_en_cnt",  256'(n_en), 256'(8));
        check_val("t2_data", mif.matrix_data, exp_word(4088));
        check_val("t2_hi_zero", 256'(mif.matrix_data[255:128]), 256'(0));

        // Hold: address change while enable stays high is ignored
        held = mif.matrix_data;
        mif.matrix_addr = c_AW'(100);
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (sif.sram_en) n_en++;
        end
        check_val("t3_hold_en", 256'(n_en), 256'(0));
        check_val("t3_hold_ready", 256'(mif.matrix_ready), 256'(1));
        check_val("t3_hold_data", mif.matrix_data, held);
        release_req();
        check_val("t3_drop_ready", 256'(mif.matrix_ready), 256'(0));
        check_val("t3_drop_data", mif.matrix_data, held);

        // Abort five cycles into the fetch
        mif.matrix_enable = 1'b1;
        mif.matrix_addr   = c_AW'(0);
        step(6);
        check_val("t4_mid_en", 256'(sif.sram_en), 256'(1));
        mif.matrix_enable = 1'b0;
        step(1);
        check_val("t4_abort_en", 256'(sif.sram_en), 256'(0));
        n_en = 0;
        for (int i = 0; i < 20; i++) if (mif.matrix_ready) n_en++; else step(1);
        check_val("t4_no_ready", 256'(n_en), 256'(0));
        seen_q.delete();
        do_request(64, lat, n_en);
        check_val("t4_latency", 256'(lat), 256'(18));
        check_val("t4_data", mif.matrix_data, exp_word(64));
        release_req();

        // Back-to-back sweep across four 64-element rows
        for (int i = 0; i < c_MEM; i++) mem[i] = c_DW'(i*37 + 11);
        seen_q.delete();
        n_bad = 0;
        for (int r = 0; r < 16; r++) begin
            do_request(r*16, lat, n_en);
            if (lat != 18 || mif.matrix_data !== exp_word(r*16)) n_bad++;
            release_req();
        end
        check_val("t5_words_bad", 256'(n_bad), 256'(0));
        check_val("t5_reads", 256'(seen_q.size()), 256'(256));
        n_bad = 0;
        foreach (seen_q[j]) if (seen_q[j] != j) n_bad++;
        check_val("t5_addr_seq", 256'(n_bad), 256'(0));

        // Reset during issue 7
        mif.matrix_enable = 1'b1;
        mif.matrix_addr   = c_AW'(512);
        step(9);
        check_val("t6_pre_addr", 256'(sif.sram_addr), 256'(512+7));
        rst = 1'b1;
        step(1);
        check_val("t6_rst_ready", 256'(mif.matrix_ready), 256'(0));
        check_val("t6_rst_en",    256'(sif.sram_en), 256'(0));
        check_val("t6_rst_data",  mif.matrix_data, '0);
        check_val("t6_rst_addr",  256'(sif.sram_addr), 256'(0));
        rst = 1'b0;
        mif.matrix_enable = 1'b0;
        step(1);
        do_request(32, lat, n_en);
        check_val("t6_latency", 256'(lat), 256'(18));
        check_val("t6_data", mif.matrix_data, exp_word(32));
        release_req();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
Upstream feeder for the matrix-vector multiplier. On a request it fetches BANDWIDTH consecutive Q2.14 matrix elements from a single-port, one-element-wide weight SRAM. It assembles them into one wide word and presents that word on the multiplier's matrix port with a ready flag. The data word is held stable until the next request, so the multiplier can keep consuming it after it deasserts its enable.

Parameters:
NUM_ROWS, 64, matrix rows stored in SRAM
NUM_COLS, 64, matrix columns stored in SRAM
DATA_WIDTH, 16, bits per element (Q2.14)
BANDWIDTH, 16, elements returned per request
ADDR_WIDTH, $clog2(NUM_ROWS*NUM_COLS), element address width (12 at defaults)

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
matrix_enable  in  1  request/hold from multiplier
matrix_addr  in  ADDR_WIDTH  base element address of request
matrix_data  out  DATA_WIDTH*BANDWIDTH  lane k = element base+k, lane 0 in LSBs
matrix_ready  out  1  matrix_data complete and valid
sram_en  out  1  SRAM read strobe
sram_addr  out  ADDR_WIDTH  SRAM element address
sram_rdata  in  DATA_WIDTH  SRAM read data, valid exactly 1 cycle after sram_en

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: matrix_ready=0, matrix_data=0, sram_en=0, sram_addr=0, state=S_IDLE, all counters=0.
- Memory size: MEM_SIZE = NUM_ROWS*NUM_COLS.
- State machine: S_IDLE, S_FETCH, S_DRAIN, S_HOLD. All states are one-hot.
- S_IDLE:
  - When matrix_enable=1 is sampled, latch base=matrix_addr, zero matrix_data, clear issue_cnt and cap_cnt, go to S_FETCH.
  - After leaving S_HOLD, matrix_enable must be seen low for at least 1 cycle before a new request is accepted; the pass through S_IDLE enforces this.
- S_FETCH:
  - One issue per cycle for k = issue_cnt = 0..BANDWIDTH-1.
  - Compute ea = base+k at ADDR_WIDTH+1 bits.
  - If ea < MEM_SIZE: sram_en=1, sram_addr=ea[ADDR_WIDTH-1:0].
  - Otherwise: sram_en=0 and that lane stays zero (no SRAM access).
  - A 1-bit-plus-lane-index pipeline register tracks each issue. The capture in the following cycle writes sram_rdata into lane k only if that issue was real.
  - After issue BANDWIDTH-1, go to S_DRAIN.
- S_DRAIN: capture the final lane, set matrix_ready=1 (registered), go to S_HOLD.
- Latency is fixed regardless of out-of-range lanes:
  - matrix_enable sampled at edge E.
  - sram_en asserted cycles E+1 .. E+BANDWIDTH.
  - matrix_ready high starting at edge E+BANDWIDTH+2 (18 cycles at default).
- S_HOLD:
  - matrix_ready=1, matrix_data stable, sram_en=0.
  - Changes on matrix_addr are ignored.
  - When matrix_enable=0 is sampled: matrix_ready=0 next cycle, go to S_IDLE. matrix_data retains its value.
- Abort: matrix_enable=0 sampled during S_FETCH or S_DRAIN:
  - Go to S_IDLE immediately, matrix_ready stays 0.
  - In-flight capture is discarded, sram_en=0 from the next cycle.
  - Partially filled matrix_data is don't-care until the next completed fetch.
- Reset mid-operation overrides everything and returns all outputs to reset values on the next edge.
- No arithmetic on data: elements pass through bit-exact.
- Address wrap-around is forbidden: out-of-range lanes are zero-filled, never wrapped to address 0.

Test Plan:
- SRAM mem[i]=i, matrix_addr=0, enable held -> sram_en high 16 cycles with addrs 0..15; matrix_ready rises 18 cycles after enable sampled; lane k = k.
- matrix_addr=4088, mem[i]=i^16'hA5A5 -> lanes 0..7 = mem[4088..4095], lanes 8..15 = 0; sram_en pulses exactly 8 times; matrix_ready still at +18.
- Hold: after ready, keep enable 10 cycles and change matrix_addr to 100 -> no sram_en, data unchanged. Drop enable -> matrix_ready=0 next cycle, matrix_data still the old word.
- Abort: drop enable 5 cycles into S_FETCH -> sram_en low next cycle, ready never asserts. A new request at addr 64 after 1 idle cycle -> lanes = mem[64..79].
- Back-to-back multiplier pattern (enable high until ready, low 1 cycle, high again with addr+16) across a full 4x64 row sweep -> every word correct, no missed or duplicate SRAM reads.
- rst asserted mid-fetch (issue 7) -> next cycle ready=0, sram_en=0, matrix_data=0, state S_IDLE; the subsequent request completes normally.
